game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/bricks_pkg.sv | 22 ++
 rtl/game_sequencer_if.sv | 28 ++
 rtl/game_sequencer_tick_divider.sv | 34 +++
 rtl/game_sequencer.sv | 149 ++++++++++++++
 tb/tb_game_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bricks_pkg.sv
// Shared encodings and field widths for the brick game sequencer,
// display and VGA blocks.
package bricks_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned LIVES_W  = 2;
  localparam int unsigned LEVEL_W  = 2;
  localparam int unsigned TICK_W   = 4;
  localparam int unsigned BRICKS_W = 96;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4,
    ST_WIN   = 3'd5
  } state_t;

endpackage

// File: rtl/game_sequencer_if.sv
// Sequencer bus: game-time strobes and playfield status in, state and
// datapath control pulses out.
//   master : drives tick/start/miss/bricks, observes state and pulses
//   slave  : the sequencer itself
interface game_sequencer_if;

  logic                                tick;
  logic                                start;
  logic                                miss;
  logic [bricks_pkg::BRICKS_W-1:0]     bricks;
  logic [bricks_pkg::STATE_W-1:0]      state;
  logic                                round_init;
  logic                                field_init;
  logic                                step_en;
  logic [bricks_pkg::LIVES_W-1:0]      lives;
  logic [bricks_pkg::LEVEL_W-1:0]      level;

  modport master (
    output tick, start, miss, bricks,
    input  state, round_init, field_init, step_en, lives, level
  );

  modport slave (
    input  tick, start, miss, bricks,
    output state, round_init, field_init, step_en, lives, level
  );

endinterface

// File: rtl/game_sequencer_tick_divider.sv
// Programmable tick divider with clear. Counts enable strobes and flags
// (combinationally) the strobe that completes a group of 'div' strobes.
//   clock, reset : system clock, synchronous active-high reset
//   clr          : restart the count (takes priority over en)
//   en           : tick strobe to count
//   div          : strobes per group, sampled each strobe
//   hit_c        : this strobe completes the group
module tick_divider
  import bricks_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [TICK_W-1:0] div,
  output logic              hit_c
);

  logic [TICK_W-1:0] cnt_q;
  logic [TICK_W:0]   next_c;

  // One extra bit so a full count of 15 compares cleanly against div.
  assign next_c = {1'b0, cnt_q} + (TICK_W + 1)'(1);
  assign hit_c  = en && (next_c >= {1'b0, div});

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= hit_c ? '0 : next_c[TICK_W-1:0];
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Brick game round/level sequencer: serve, play, miss/win/over banners,
// lives and level bookkeeping, ball step pacing.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : tick/start/miss/bricks in; state, round_init,
//                  field_init, step_en, lives, level out (all registered)
module game_sequencer
  import bricks_pkg::*;
#(
  parameter int unsigned LIVES_INIT  = 3,
  parameter int unsigned SERVE_TICKS = 4,
  parameter int unsigned OVER_TICKS  = 8,
  parameter int unsigned BASE_DIV    = 4
) (
  input  logic             clock,
  input  logic             reset,
  game_sequencer_if.slave  bus
);

  state_t               state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic                 round_init_q, round_init_d;
  logic                 field_init_q, field_init_d;
  logic                 step_en_q, step_en_d;
  logic [TICK_W-1:0]    div_c;
  logic                 hit_c;
  logic                 clr_c;

  // Divider length per state; kept apart from the FSM so hit_c has no
  // path back through the next-state logic.
  always_comb begin
    div_c = TICK_W'(OVER_TICKS);
    if (state_q == ST_SERVE) begin
      div_c = TICK_W'(SERVE_TICKS);
    end else if (state_q == ST_PLAY) begin
      div_c = TICK_W'(BASE_DIV) - TICK_W'(level_q);
    end
  end

  // Shared tick counter: restarts on every state change, so the entry
  // clock's tick is never counted.
  tick_divider u_tick_divider (
    .clock (clock),
    .reset (reset),
    .clr   (clr_c),
    .en    (bus.tick),
    .div   (div_c),
    .hit_c (hit_c)
  );

  // State register and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      lives_q      <= '0;
      level_q      <= '0;
      round_init_q <= 1'b0;
      field_init_q <= 1'b0;
      step_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      round_init_q <= round_init_d;
      field_init_q <= field_init_d;
      step_en_q    <= step_en_d;
    end
  end

  // Next state and next outputs.
  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    level_d      = level_q;
    round_init_d = 1'b0;
    field_init_d = 1'b0;
    step_en_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d      = ST_SERVE;
          field_init_d = 1'b1;
          round_init_d = 1'b1;
          lives_d      = LIVES_W'(LIVES_INIT);
          level_d      = '0;
        end
      end
      ST_SERVE: begin
        // Early serve: start beats a coincident tick, same outcome either way.
        if (bus.start || hit_c) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // Cleared field outranks a miss; a step never fires on the exit clock.
        if (bus.bricks == '0) begin
          state_d = ST_WIN;
        end else if (bus.miss) begin
          if (lives_q <= LIVES_W'(1)) begin
            lives_d = '0;
            state_d = ST_OVER;
          end else begin
            lives_d = lives_q - LIVES_W'(1);
            state_d = ST_MISS;
          end
        end else if (hit_c) begin
          step_en_d = 1'b1;
        end
      end
      ST_MISS: begin
        if (hit_c) begin
          state_d      = ST_SERVE;
          round_init_d = 1'b1;
        end
      end
      ST_WIN: begin
        if (hit_c) begin
          if (level_q != LEVEL_MAX) begin
            level_d      = level_q + LEVEL_W'(1);
            field_init_d = 1'b1;
            round_init_d = 1'b1;
            state_d      = ST_SERVE;
          end else begin
            state_d = ST_OVER;
          end
        end
      end
      ST_OVER: begin
        if (hit_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    clr_c = (state_d != state_q);
  end

  assign bus.state      = state_q;
  assign bus.lives      = lives_q;
  assign bus.level      = level_q;
  assign bus.round_init = round_init_q;
  assign bus.field_init = field_init_q;
  assign bus.step_en    = step_en_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: expected snapshots are queued as
// stimulus is driven and compared against the DUT once it has responded.
module tb_game_sequencer;

  typedef struct packed {
    logic [2:0] state;
    logic [1:0] lives;
    logic [1:0] level;
    logic [7:0] steps;
    logic [3:0] rinit;
    logic [3:0] finit;
  } obs_t;

  logic clock;
  logic reset;
  game_sequencer_if bus ();

  game_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int tot_step = 0, tot_ri = 0, tot_fi = 0, viol = 0;
  int s_step = 0, s_ri = 0, s_fi = 0;
  logic p_step = 1'b0, p_ri = 1'b0, p_fi = 1'b0;
  obs_t exp_q[$];
  obs_t e, o;

  // Pulse monitor: counts pulses and flags any that last two clocks or a
  // step outside PLAY.
  always @(negedge clock) begin
    if (bus.step_en === 1'b1) tot_step++;
    if (bus.round_init === 1'b1) tot_ri++;
    if (bus.field_init === 1'b1) tot_fi++;
    if ((bus.step_en === 1'b1 && p_step) || (bus.round_init === 1'b1 && p_ri) ||
        (bus.field_init === 1'b1 && p_fi) ||
        (bus.step_en === 1'b1 && bus.state !== 3'd2)) viol++;
    p_step = (bus.step_en === 1'b1);
    p_ri   = (bus.round_init === 1'b1);
    p_fi   = (bus.field_init === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_tick(input int n);
    repeat (n) begin
      bus.tick = 1'b1; cyc();
      bus.tick = 1'b0; cyc();
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; cyc();
    bus.start = 1'b0; cyc();
  endtask

  task automatic pulse_miss();
    bus.miss = 1'b1; cyc();
    bus.miss = 1'b0; cyc();
  endtask

  task automatic clear_field_with_miss(input logic with_miss);
    bus.bricks = '0;
    bus.miss   = with_miss;
    cyc();
    bus.bricks = {$urandom, $urandom, $urandom} | 96'd1;
    bus.miss   = 1'b0;
    cyc();
  endtask

  task automatic mark();
    s_step = tot_step; s_ri = tot_ri; s_fi = tot_fi;
  endtask

  function automatic obs_t mk(int st, int lv, int lvl, int stp, int ri, int fi);
    obs_t r;
    r.state = 3'(st); r.lives = 2'(lv); r.level = 2'(lvl);
    r.steps = 8'(stp); r.rinit = 4'(ri); r.finit = 4'(fi);
    return r;
  endfunction

  function automatic obs_t obs_now();
    obs_t r;
    r.state = bus.state; r.lives = bus.lives; r.level = bus.level;
    r.steps = 8'(tot_step - s_step);
    r.rinit = 4'(tot_ri - s_ri);
    r.finit = 4'(tot_fi - s_fi);
    return r;
  endfunction

  task automatic test_reset();
    mark();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    reset = 1'b1; bus.start = 1'b1; bus.tick = 1'b1;
    repeat (3) cyc();
    bus.start = 1'b0; bus.tick = 1'b0; reset = 1'b0;
    cyc();
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL reset_values: got %h want %h", o, e); end
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    do_tick(5);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL idle_ticks: got %h want %h", o, e); end
  endtask

  task automatic test_start_serve();
    mark();
    exp_q.push_back(mk(1, 3, 0, 0, 1, 1));
    pulse_start();
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL start_to_serve: got %h want %h", o, e); end
    exp_q.push_back(mk(1, 3, 0, 0, 1, 1));
    do_tick(3);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL serve_3_ticks: got %h want %h", o, e); end
    exp_q.push_back(mk(2, 3, 0, 0, 1, 1));
    do_tick(1);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL serve_to_play: got %h want %h", o, e); end
  endtask

  task automatic test_step_level0();
    mark();
    exp_q.push_back(mk(2, 3, 0, 0, 0, 0));
    exp_q.push_back(mk(2, 3, 0, 1, 0, 0));
    exp_q.push_back(mk(2, 3, 0, 3, 0, 0));
    do_tick(3);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL step0_before_first: got %h want %h", o, e); end
    do_tick(1);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL step0_first: got %h want %h", o, e); end
    do_tick(8);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL step0_12_ticks: got %h want %h", o, e); end
  endtask

  task automatic test_miss();
    mark();
    exp_q.push_back(mk(3, 2, 0, 0, 0, 0));
    pulse_miss();
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL miss1_enter: got %h want %h", o, e); end
    exp_q.push_back(mk(3, 2, 0, 0, 0, 0));
    pulse_start();
    do_tick(7);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL miss1_7_ticks: got %h want %h", o, e); end
    exp_q.push_back(mk(1, 2, 0, 0, 1, 0));
    do_tick(1);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL miss1_to_serve: got %h want %h", o, e); end
    exp_q.push_back(mk(1, 1, 0, 0, 2, 0));
    pulse_start();
    pulse_miss();
    do_tick(8);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL miss2_to_serve: got %h want %h", o, e); end
    exp_q.push_back(mk(4, 0, 0, 0, 2, 0));
    pulse_start();
    pulse_miss();
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL miss3_over: got %h want %h", o, e); end
    exp_q.push_back(mk(4, 0, 0, 0, 2, 0));
    pulse_start();
    do_tick(7);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL over_start_ignored: got %h want %h", o, e); end
    exp_q.push_back(mk(0, 0, 0, 0, 2, 0));
    do_tick(1);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL over_to_idle: got %h want %h", o, e); end
  endtask

  task automatic test_early_serve();
    mark();
    exp_q.push_back(mk(2, 3, 0, 0, 1, 1));
    exp_q.push_back(mk(2, 3, 0, 0, 1, 1));
    pulse_start();
    do_tick(1);
    bus.start = 1'b1; bus.tick = 1'b1; cyc();
    bus.start = 1'b0; bus.tick = 1'b0;
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL early_serve: got %h want %h", o, e); end
    cyc();
    pulse_start();
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL play_start_ignored: got %h want %h", o, e); end
  endtask

  task automatic test_win();
    mark();
    exp_q.push_back(mk(5, 3, 0, 0, 0, 0));
    clear_field_with_miss(1'b1);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL win_beats_miss: got %h want %h", o, e); end
    exp_q.push_back(mk(5, 3, 0, 0, 0, 0));
    do_tick(7);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL win_7_ticks: got %h want %h", o, e); end
    exp_q.push_back(mk(1, 3, 1, 0, 1, 1));
    do_tick(1);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL win_to_level1: got %h want %h", o, e); end
    exp_q.push_back(mk(2, 3, 2, 0, 2, 2));
    pulse_start();
    clear_field_with_miss(1'b0);
    do_tick(8);
    pulse_start();
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL play_level2: got %h want %h", o, e); end
  endtask

  task automatic test_step_level2();
    mark();
    exp_q.push_back(mk(2, 3, 2, 0, 0, 0));
    exp_q.push_back(mk(2, 3, 2, 1, 0, 0));
    exp_q.push_back(mk(2, 3, 2, 6, 0, 0));
    do_tick(1);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL step2_before_first: got %h want %h", o, e); end
    do_tick(1);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL step2_first: got %h want %h", o, e); end
    do_tick(10);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL step2_12_ticks: got %h want %h", o, e); end
  endtask

  task automatic test_level_saturate();
    mark();
    exp_q.push_back(mk(2, 3, 3, 2, 1, 1));
    clear_field_with_miss(1'b0);
    do_tick(8);
    pulse_start();
    do_tick(2);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL level3_step_every_tick: got %h want %h", o, e); end
    exp_q.push_back(mk(4, 3, 3, 2, 1, 1));
    clear_field_with_miss(1'b0);
    do_tick(8);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL level3_win_to_over: got %h want %h", o, e); end
    exp_q.push_back(mk(0, 3, 3, 2, 1, 1));
    do_tick(8);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL level3_over_to_idle: got %h want %h", o, e); end
  endtask

  task automatic test_reset_mid_play();
    logic [9:0] got;
    mark();
    exp_q.push_back(mk(2, 3, 0, 0, 1, 1));
    pulse_start();
    pulse_start();
    do_tick(3);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL rst_play_setup: got %h want %h", o, e); end
    // The fourth tick would fire step_en; reset lands on that same clock.
    reset = 1'b1; bus.tick = 1'b1; cyc();
    got = {bus.state, bus.lives, bus.level, bus.step_en, bus.round_init, bus.field_init};
    n_cmp++;
    if (got !== 10'd0) begin
      n_bad++;
      $display("FAIL rst_on_step_clock: got %b want %b (state,lives,level,step,ri,fi)", got, 10'd0);
    end
    reset = 1'b0; bus.tick = 1'b0; cyc();
    exp_q.push_back(mk(0, 0, 0, 0, 1, 1));
    do_tick(6);
    e = exp_q.pop_front(); o = obs_now(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL rst_quiet_after: got %h want %h", o, e); end
  endtask

  task automatic test_pulse_shape();
    n_cmp++;
    if (viol !== 0) begin n_bad++; $display("FAIL pulse_shape: got %0d violations want 0", viol); end
    n_cmp++;
    if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    reset      = 1'b1;
    bus.tick   = 1'b0;
    bus.start  = 1'b0;
    bus.miss   = 1'b0;
    bus.bricks = {$urandom, $urandom, $urandom} | 96'd1;
    test_reset();
    test_start_serve();
    test_step_level0();
    test_miss();
    test_early_serve();
    test_win();
    test_step_level2();
    test_level_saturate();
    test_reset_mid_play();
    test_pulse_shape();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
